shl_seq: RTL and testbench



---
 rtl/shl_seq.sv | 127 ++++++++++++
 tb/tb_shl_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/shl_seq.sv
// Multi-cycle logical shift left / rotate left, one bit per clock.
// A start/done handshake brackets each operation; Z holds the last result.
module shl_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int SH_WIDTH   = 5
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  start,
   input  logic                  op,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] Z,
   output logic                  cout,
   output logic [1:0]            o_dbg_state
);

   // Handshake: start is sampled on each rising edge and is accepted only
   // in IDLE or DONE; done is a one-cycle pulse in which Z and cout are valid.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [SH_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [SH_WIDTH-1:0] CNT_ONE  = {{(SH_WIDTH-1){1'b0}}, 1'b1};

   state_t                r_state;
   state_t                w_next;
   logic [DATA_WIDTH-1:0] r_val;
   logic [DATA_WIDTH-1:0] r_z;
   logic [SH_WIDTH-1:0]   r_cnt;
   logic                  r_op;
   logic                  r_cout;
   logic                  r_busy;
   logic                  r_done;

   logic [SH_WIDTH-1:0]   w_b_amt;
   logic [DATA_WIDTH-1:0] w_shifted;
   logic                  w_accept;
   logic                  w_last_step;
   logic                  w_unused_b;

   always_comb begin
      w_b_amt     = B[SH_WIDTH-1:0];
      w_accept    = start && (r_state != S_SHIFT);
      w_last_step = (r_state == S_SHIFT) && (r_cnt == CNT_ONE);
      w_shifted   = {r_val[DATA_WIDTH-2:0], r_op ? r_val[DATA_WIDTH-1] : 1'b0};
   end

   // Upper shift-amount bits are deliberately ignored.
   assign w_unused_b = ^B[DATA_WIDTH-1:SH_WIDTH];

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = (w_b_amt == CNT_ZERO) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_cnt == CNT_ONE) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            if (w_accept) begin
               w_next = (w_b_amt == CNT_ZERO) ? S_DONE : S_SHIFT;
            end else begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // busy/done are registered from the next state so they never glitch.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == S_SHIFT);
         r_done  <= (w_next == S_DONE);
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_val  <= '0;
         r_cnt  <= '0;
         r_op   <= 1'b0;
         r_cout <= 1'b0;
         r_z    <= '0;
      end else if (w_accept) begin
         r_val  <= A;
         r_cnt  <= w_b_amt;
         r_op   <= op;
         r_cout <= 1'b0;
         if (w_b_amt == CNT_ZERO) begin
            r_z <= A;
         end
      end else if (r_state == S_SHIFT) begin
         r_val  <= w_shifted;
         r_cnt  <= r_cnt - CNT_ONE;
         r_cout <= r_val[DATA_WIDTH-1];
         if (w_last_step) begin
            r_z <= w_shifted;
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign Z           = r_z;
   assign cout        = r_cout;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shl_seq.sv
// Directed bench for shl_seq: hand-computed vectors checked with immediate
// assertions, covering latency, masking, rotate carry, lockout and reset.
module tb_shl_seq;

   logic        clock;
   logic        clear;
   logic        start;
   logic        op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] Z;
   logic        cout;
   logic [1:0]  dbg_state;

   int          n_cmp;
   int          n_fail;
   logic [31:0] last_z;

   shl_seq #(.DATA_WIDTH(32), .SH_WIDTH(5)) dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .op          (op),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .Z           (Z),
      .cout        (cout),
      .o_dbg_state (dbg_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Start at the next edge; done is expected lat cycles after that edge.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic o, input logic [31:0] ez, input logic ec, input int lat);
      A = a; B = b; op = o; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < lat; c++) begin
         chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
         chk({tag, "_nodone"}, {31'b0, done}, 32'd0);
         chk({tag, "_zhold"}, Z, last_z);
         step();
      end
      chk({tag, "_done"}, {31'b0, done}, 32'd1);
      chk({tag, "_busy_lo"}, {31'b0, busy}, 32'd0);
      chk({tag, "_z"}, Z, ez);
      chk({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
      last_z = ez;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      last_z = 32'h0;
      clear  = 1'b1;
      start  = 1'b0;
      op     = 1'b0;
      A      = 32'h0;
      B      = 32'h0;
      step();
      step();
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_z", Z, 32'h0);
      chk("rst_cout", {31'b0, cout}, 32'd0);
      chk("rst_state", {30'b0, dbg_state}, 32'd0);
      clear = 1'b0;
      step();
      chk("idle_busy", {31'b0, busy}, 32'd0);

      run_op("shl4", 32'h0000_0001, 32'd4, 1'b0, 32'h0000_0010, 1'b0, 5);
      step();
      chk("done_to_idle", {31'b0, done}, 32'd0);
      chk("idle_state", {30'b0, dbg_state}, 32'd0);

      run_op("rol1", 32'h8000_0001, 32'd1, 1'b1, 32'h0000_0003, 1'b1, 2);
      step();
      run_op("shl4_carry", 32'hF000_0000, 32'd4, 1'b0, 32'h0000_0000, 1'b1, 5);
      step();
      run_op("mask5", 32'h1234_5678, 32'h0000_0025, 1'b0, 32'h468A_CF00, 1'b0, 6);
      step();
      run_op("zero_amt", 32'h1234_5678, 32'h0000_0020, 1'b1, 32'h1234_5678, 1'b0, 1);
      step();
      run_op("max31", 32'hFFFF_FFFF, 32'd31, 1'b0, 32'h8000_0000, 1'b1, 32);
      // Issued in the done cycle of the previous op: back-to-back.
      run_op("b2b_rol", 32'h0000_0003, 32'd2, 1'b1, 32'h0000_000C, 1'b0, 3);
      step();

      // Start re-asserted during SHIFT must be ignored.
      A = 32'h0000_0001; B = 32'd8; op = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      chk("lock_zhold", Z, last_z);
      step();
      step();
      A = 32'h0000_00FF; B = 32'd1; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 4; c < 9; c++) begin
         chk("lock_busy", {31'b0, busy}, 32'd1);
         step();
      end
      chk("lock_done", {31'b0, done}, 32'd1);
      chk("lock_z", Z, 32'h0000_0100);
      chk("lock_cout", {31'b0, cout}, 32'd0);
      last_z = 32'h0000_0100;
      step();

      // Asynchronous clear in the middle of a shift.
      A = 32'h0000_0005; B = 32'd10; op = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("mid_busy", {31'b0, busy}, 32'd1);
      #2 clear = 1'b1;
      #1;
      chk("aclr_busy", {31'b0, busy}, 32'd0);
      chk("aclr_done", {31'b0, done}, 32'd0);
      chk("aclr_z", Z, 32'h0);
      chk("aclr_cout", {31'b0, cout}, 32'd0);
      chk("aclr_state", {30'b0, dbg_state}, 32'd0);
      last_z = 32'h0;
      step();
      clear = 1'b0;
      step();
      chk("post_busy", {31'b0, busy}, 32'd0);
      chk("post_done", {31'b0, done}, 32'd0);
      run_op("post_shl2", 32'h0000_0005, 32'd2, 1'b0, 32'h0000_0014, 1'b0, 3);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
